if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV32I core. Drives PC register (PCNext/load): next PC = PC+4 or redirect target.
//  Issues one instruction-memory request at a time and hands the fetched word plus its PC to decode (valid/ready).
//  Squashes wrong-path fetches on branch/jump redirect from execute; flags misaligned fetch addresses.
// PARAMETERS
//  ADDR_W     32            address / PC width
//  DATA_W     32            instruction word width
//  NOP_INSTR  32'h00000013  word presented to decode with id_fault (addi x0,x0,0)
// PORTS
//  clk              in   1       core clock, all state on rising edge
//  areset           in   1       synchronous, active-high reset
//  pc               in   ADDR_W  current PC from PC register
//  pc_next          out  ADDR_W  PCNext to PC register
//  pc_load          out  1       load strobe to PC register
//  redirect_valid   in   1       execute redirect (taken branch/jump), 1-cycle pulse
//  redirect_target  in   ADDR_W  redirect destination
//  imem_req_valid   out  1       fetch request valid
//  imem_req_ready   in   1       imem accepts request
//  imem_req_addr    out  ADDR_W  fetch address
//  imem_rsp_valid   in   1       response valid, 1-cycle pulse per accepted request
//  imem_rsp_data    in   DATA_W  fetched word
//  id_valid         out  1       instruction valid to decode
//  id_ready         in   1       decode accepts
//  id_instr         out  DATA_W  instruction word
//  id_pc            out  ADDR_W  PC of id_instr
//  id_fault         out  1       misaligned-fetch marker for id_instr
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, DROP, HOLD, STALL. Max one outstanding imem request.
//  Reset (areset=1 at edge): state IDLE; id_valid=0, id_instr=0, id_pc=0, id_fault=0, internal req_pc=0.
//   pc_load/imem_req_valid are 0 while in IDLE. Imem shares areset and discards outstanding requests.
//  IDLE: -> REQ unconditionally next cycle.
//  REQ: if pc[1:0]!=0: no request; latch id_instr=NOP_INSTR, id_pc=pc, id_fault=1 -> HOLD.
//   else imem_req_valid=1, imem_req_addr=pc; on req_ready: req_pc<=pc, pc_load=1, pc_next=pc+4 (mod 2^32) -> WAIT.
//  WAIT: on rsp_valid: id_instr<=rsp_data, id_pc<=req_pc, id_fault<=0, id_valid<=1 -> HOLD.
//  HOLD: id_valid held, id_instr/id_pc/id_fault stable until id_valid&&id_ready; then id_valid<=0 and
//   -> REQ (fault=0) or -> STALL (fault=1). No new request issued while in HOLD.
//  STALL: idle, no requests, no pc_load; leave only via redirect.
//  DROP: outstanding request is wrong-path; on rsp_valid discard data -> REQ.
//  Redirect (any state except IDLE) has priority over all other events in the same cycle:
//   pc_load=1, pc_next=redirect_target; imem_req_valid forced 0 that cycle (no request accepted).
//   WAIT without rsp_valid -> DROP; WAIT with simultaneous rsp_valid -> response discarded, -> REQ.
//   HOLD: id_valid output masked to 0 that cycle (id_valid = hold_valid & ~redirect_valid), transfer does
//   not occur even if id_ready=1; id_valid<=0 -> REQ. DROP: stays DROP (target already loaded).
//   REQ, STALL -> REQ.
//  pc_load is 1 only on request handshake or redirect; otherwise 0 (PC holds).
//  Latency: zero-wait imem gives id_valid 2 cycles after request handshake cycle; peak 1 instr / 3 cycles.
//  areset asserted in any state, including WAIT/HOLD mid-transfer: next cycle state IDLE with reset values.
// TESTING
//  T1 reset, pc=0, ready=1, rsp 1 cycle later data 32'h00500093 -> req addr 0, pc_load pc_next=4; id_pc=0, id_instr=00500093.
//  T2 id_ready=0 for 5 cycles in HOLD -> id_valid=1, id_instr/id_pc stable, imem_req_valid=0, pc_load=0 throughout.
//  T3 redirect to 0x100 in WAIT, late rsp 2 cycles later -> pc_next=0x100 pc_load=1, rsp dropped, next req addr 0x100.
//  T4 redirect to 0x80 same cycle as rsp_valid -> id_valid stays 0, next req addr 0x80.
//  T5 pc=0x102 -> no imem request, id_valid=1 id_instr=00000013 id_fault=1; STALL until redirect 0x200 -> req addr 0x200.
//  T6 redirect in HOLD with id_ready=1 -> id_valid=0 that cycle, no transfer; areset in WAIT -> next cycle IDLE, id_valid=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC update strobe, keeps at most one
// imem request in flight, and hands fetched words (or a misaligned-fetch NOP) to decode.
module if_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_load,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD,
    S_STALL
  } state_t;

  state_t              state_q, state_d;
  logic                id_valid_q, id_valid_d;
  logic [DATA_W-1:0]   id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]   id_pc_q, id_pc_d;
  logic                id_fault_q, id_fault_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;

  logic                redirect_take;
  logic                misaligned;
  logic                req_hs;

  always_comb begin
    state_d        = state_q;
    id_valid_d     = id_valid_q;
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    id_fault_d     = id_fault_q;
    req_pc_d       = req_pc_q;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;
    req_hs         = 1'b0;

    // A redirect outranks every other event in the cycle it arrives.
    redirect_take  = redirect_valid && (state_q != S_IDLE);
    misaligned     = (pc[1:0] != 2'b00);

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect_take) begin
          state_d = S_REQ;
        end else if (misaligned) begin
          id_valid_d = 1'b1;
          id_instr_d = NOP_INSTR;
          id_pc_d    = pc;
          id_fault_d = 1'b1;
          state_d    = S_HOLD;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            req_hs   = 1'b1;
            req_pc_d = pc;
            state_d  = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (redirect_take) begin
          // A response landing with the redirect is wrong-path and retires the request.
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          id_valid_d = 1'b1;
          id_instr_d = imem_rsp_data;
          id_pc_d    = req_pc_q;
          id_fault_d = 1'b0;
          state_d    = S_HOLD;
        end
      end

      S_DROP: begin
        // Still owed one response; only once it has arrived may a new request go out.
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        if (redirect_take) begin
          id_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          state_d    = id_fault_q ? S_STALL : S_REQ;
        end
      end

      S_STALL: begin
        if (redirect_take) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_load  = redirect_take | req_hs;
  assign pc_next  = redirect_take ? redirect_target : (pc + ADDR_W'(4));
  assign id_valid = id_valid_q & ~redirect_valid;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_fault = id_fault_q;

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_fault_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_fault_q <= id_fault_d;
      req_pc_q   <= req_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level fetch model plus PC register and
// latency-programmable imem, checked every cycle, with hand-computed pins.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        areset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  if_fetch_unit dut (
    .clk             (clk),
    .areset          (areset),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_load         (pc_load),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_fault        (id_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level view of the fetch stage.
  logic        m_cold, m_out, m_wrong, m_full, m_stall, m_fault;
  logic [31:0] m_instr, m_pc_id, m_req_pc, m_pc;
  // Imem plant: one outstanding request, response after lat cycles.
  int          lat = 1;
  int          imem_cnt = 0;
  logic [31:0] imem_addr = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy,
                      input logic idr, input logic rst);
    logic        issue, e_req, e_load, e_idv;
    logic [31:0] e_next;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (imem_cnt > 0) begin
      imem_cnt--;
      if (imem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(imem_addr);
      end
    end
    areset          = rst;
    redirect_valid  = rd;
    redirect_target = tgt;
    imem_req_ready  = rdy;
    id_ready        = idr;
    pc              = m_pc;
    #1;
    issue  = !m_cold && !m_out && !m_full && !m_stall;
    e_req  = issue && !rd && (m_pc[1:0] == 2'b00);
    e_load = !m_cold && (rd || (e_req && rdy));
    e_next = rd ? tgt : m_pc + 32'd4;
    e_idv  = m_full && !rd;
    if (!rst) begin
      chk("id_valid", {31'b0, id_valid}, {31'b0, e_idv});
      chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      chk("pc_load", {31'b0, pc_load}, {31'b0, e_load});
      chk("id_instr", id_instr, m_instr);
      chk("id_pc", id_pc, m_pc_id);
      chk("id_fault", {31'b0, id_fault}, {31'b0, m_fault});
      if (e_req)  chk("imem_req_addr", imem_req_addr, m_pc);
      if (e_load) chk("pc_next", pc_next, e_next);
    end
    if (rst) begin
      m_cold = 1; m_out = 0; m_wrong = 0; m_full = 0; m_stall = 0; m_fault = 0;
      m_instr = 0; m_pc_id = 0; m_req_pc = 0; m_pc = 0; imem_cnt = 0;
    end else if (m_cold) begin
      m_cold = 0;
    end else if (rd) begin
      m_stall = 0;
      m_full  = 0;
      if (m_out) begin
        if (imem_rsp_valid) m_out = 0;
        else                m_wrong = 1;
      end
      m_pc = tgt;
    end else if (imem_rsp_valid && m_out) begin
      m_out = 0;
      if (!m_wrong) begin
        m_full = 1; m_instr = imem_rsp_data; m_pc_id = m_req_pc; m_fault = 0;
      end
      m_wrong = 0;
    end else if (m_full && idr) begin
      m_full = 0;
      if (m_fault) m_stall = 1;
    end else if (issue) begin
      if (m_pc[1:0] != 2'b00) begin
        m_full = 1; m_instr = NOP; m_pc_id = m_pc; m_fault = 1;
      end else if (rdy) begin
        m_out = 1; m_wrong = 0; m_req_pc = m_pc;
        imem_cnt = lat; imem_addr = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input logic rd, input logic [31:0] tgt, input logic rdy, input logic idr);
    step(rd, tgt, rdy, idr, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; pc = 0; redirect_valid = 0; redirect_target = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; id_ready = 0;
    m_cold = 1; m_out = 0; m_wrong = 0; m_full = 0; m_stall = 0; m_fault = 0;
    m_instr = 0; m_pc_id = 0; m_req_pc = 0; m_pc = 0;

    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);

    // T1: reset values, first fetch from 0
    cyc(0, 0, 1, 1);
    chk("rst id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst id_instr", id_instr, 32'h0);
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc(0, 0, 1, 0);
    chk("t1 req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1 req_addr", imem_req_addr, 32'h0);
    chk("t1 pc_next", pc_next, 32'h4);
    cyc(0, 0, 1, 0);
    // T2: decode back-pressure for 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      chk("t2 id_valid", {31'b0, id_valid}, 32'd1);
      chk("t2 id_instr", id_instr, 32'h00500093);
      chk("t2 id_pc", id_pc, 32'h0);
      chk("t2 req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("t2 pc_load", {31'b0, pc_load}, 32'd0);
    end
    cyc(0, 0, 1, 1);

    // T3: redirect in WAIT, late response dropped
    lat = 3;
    cyc(0, 0, 1, 0);
    chk("t3 req_addr", imem_req_addr, 32'h4);
    cyc(1, 32'h100, 1, 0);
    chk("t3 pc_load", {31'b0, pc_load}, 32'd1);
    chk("t3 pc_next", pc_next, 32'h100);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t3 drop id_valid", {31'b0, id_valid}, 32'd0);
    chk("t3 drop req_valid", {31'b0, imem_req_valid}, 32'd0);
    lat = 1;
    cyc(0, 0, 1, 0);
    chk("t3 req_addr2", imem_req_addr, 32'h100);

    // T4: redirect coincident with response
    cyc(1, 32'h80, 1, 1);
    chk("t4 id_valid", {31'b0, id_valid}, 32'd0);
    chk("t4 pc_next", pc_next, 32'h80);
    cyc(0, 0, 1, 1);
    chk("t4 id_valid2", {31'b0, id_valid}, 32'd0);
    chk("t4 req_addr", imem_req_addr, 32'h80);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("t4 id_pc", id_pc, 32'h80);
    chk("t4 id_instr", id_instr, 32'h00008013);

    // T5: misaligned fetch, stall until redirect
    cyc(1, 32'h102, 1, 1);
    cyc(0, 0, 1, 1);
    chk("t5 no req", {31'b0, imem_req_valid}, 32'd0);
    cyc(0, 0, 1, 1);
    chk("t5 id_valid", {31'b0, id_valid}, 32'd1);
    chk("t5 id_instr", id_instr, NOP);
    chk("t5 id_fault", {31'b0, id_fault}, 32'd1);
    chk("t5 id_pc", id_pc, 32'h102);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1);
      chk("t5 stall req", {31'b0, imem_req_valid}, 32'd0);
      chk("t5 stall load", {31'b0, pc_load}, 32'd0);
    end
    cyc(1, 32'h200, 1, 1);
    cyc(0, 0, 1, 1);
    chk("t5 req_addr", imem_req_addr, 32'h200);
    cyc(0, 0, 1, 1);

    // T6: redirect in HOLD with id_ready, then reset mid-WAIT
    cyc(1, 32'h300, 1, 1);
    chk("t6 hold id_valid", {31'b0, id_valid}, 32'd0);
    lat = 3;
    cyc(0, 0, 1, 1);
    chk("t6 req_addr", imem_req_addr, 32'h300);
    step(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1);
    chk("t6 rst id_valid", {31'b0, id_valid}, 32'd0);
    chk("t6 rst id_pc", id_pc, 32'h0);
    chk("t6 rst req_valid", {31'b0, imem_req_valid}, 32'd0);

    // Mixed traffic: varying latency, ready and back-pressure, periodic redirects
    for (int i = 0; i < 80; i++) begin
      lat = 1 + (i % 3);
      cyc((i % 17) == 16, 32'h400 + 32'(i) * 32'd16, (i % 4) != 3, (i % 3) != 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
